ethpipe_csr: RTL and testbench



---
 rtl/ethpipe_csr_pkg.sv | 34 +++
 rtl/ethpipe_csr_chan.sv | 49 ++++
 rtl/ethpipe_csr.sv | 130 +++++++++++++
 tb/tb_ethpipe_csr.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ethpipe_csr_pkg.sv
// Shared word map, ID byte, reset values and byte-lane helpers for ethpipe_csr.
package ethpipe_csr_pkg;

  localparam logic [5:0] W_ID       = 6'h00;
  localparam logic [5:0] W_CNT0     = 6'h02;
  localparam logic [5:0] W_STATUS   = 6'h08;
  localparam logic [5:0] W_MASK     = 6'h09;
  localparam logic [5:0] W_LEN_LO   = 6'h0A;
  localparam logic [5:0] W_LEN_HI   = 6'h0B;
  localparam logic [5:0] W_CH_BASE  = 6'h10;
  localparam logic [5:0] W_PTR_BASE = 6'h30;
  localparam int W_CH_STRIDE  = 4;
  localparam int W_PTR_STRIDE = 2;

  localparam logic [7:0]  ID_BYTE        = 8'hE1;
  localparam logic [19:0] RST_DMA_LENGTH = 20'(32'h0001_0000 >> 2);
  localparam logic [31:0] RST_ADDR_BASE  = 32'h1000_0000;
  localparam logic [31:0] RST_ADDR_STEP  = 32'h0010_0000;

  // The bus carries register bits [7:0] on dat[15:8] and [15:8] on dat[7:0].
  function automatic logic [15:0] lane_swap(input logic [15:0] v);
    return {v[7:0], v[15:8]};
  endfunction

  function automatic logic [15:0] wr_merge(input logic [15:0] old, input logic [15:0] dat,
                                           input logic [1:0] sel);
    logic [15:0] r;
    r = old;
    if (sel[1]) r[7:0]  = dat[15:8];
    if (sel[0]) r[15:8] = dat[7:0];
    return r;
  endfunction

endpackage

// File: rtl/ethpipe_csr_chan.sv
// One Ethernet channel's CSR state: DMA start address, TX write pointer,
// interrupt status bit and the registered dma_load strobe.
module ethpipe_csr_chan
  import ethpipe_csr_pkg::*;
#(
  parameter int CH_IDX = 0,
  parameter int PTR_W  = 14
) (
  input  logic             clk_125,
  input  logic             sys_rst,
  input  logic             wr_start_lo,
  input  logic             wr_start_hi,
  input  logic             wr_ptr,
  input  logic             wr_status,
  input  logic             len_load,
  input  logic [15:0]      wdat,
  input  logic [1:0]       wsel,
  input  logic             intr,
  output logic [29:0]      dma_addr_start,
  output logic [PTR_W-1:0] tx_wr_ptr,
  output logic             status,
  output logic             dma_load
);

  localparam logic [29:0] RST_START = 30'((RST_ADDR_BASE + RST_ADDR_STEP * CH_IDX) >> 2);

  logic clr;
  assign clr = wr_status & wsel[1] & wdat[8+CH_IDX];

  always_ff @(posedge clk_125 or posedge sys_rst) begin
    if (sys_rst) begin
      dma_addr_start <= RST_START;
      tx_wr_ptr      <= '0;
      status         <= 1'b0;
      dma_load       <= 1'b0;
    end else begin
      dma_load <= wr_start_lo | wr_start_hi | len_load;
      // a new request outranks a clear landing on the same edge
      status   <= intr | (status & ~clr);
      if (wr_start_lo)
        dma_addr_start[13:0] <= 14'(wr_merge({dma_addr_start[13:0], 2'b00}, wdat, wsel) >> 2);
      if (wr_start_hi)
        dma_addr_start[29:14] <= wr_merge(dma_addr_start[29:14], wdat, wsel);
      if (wr_ptr)
        tx_wr_ptr <= PTR_W'(wr_merge(16'(tx_wr_ptr), wdat, wsel));
    end
  end

endmodule

// File: rtl/ethpipe_csr.sv
// BAR0 CSR window for ethpipe: decode, global counter with snapshot, read mux.
// Optional writable interrupt mask at word 0x09 via `ETHPIPE_CSR_INTR_MASK_EN.
module ethpipe_csr
  import ethpipe_csr_pkg::*;
#(
  parameter int CHANNELS = 2,
  parameter int PTR_W    = 14
) (
  input  logic                  clk_125,
  input  logic                  sys_rst,
  input  logic                  slv_hit_i,
  input  logic                  slv_ce_i,
  input  logic                  slv_we_i,
  input  logic [11:1]           slv_adr_i,
  input  logic [15:0]           slv_dat_i,
  input  logic [1:0]            slv_sel_i,
  output logic [15:0]           slv_dat_o,
  output logic [63:0]           global_counter,
  output logic [19:0]           dma_length,
  output logic [30*CHANNELS-1:0] dma_addr_start,
  input  logic [30*CHANNELS-1:0] dma_addr_cur,
  output logic [CHANNELS-1:0]   dma_load,
  output logic [PTR_W*CHANNELS-1:0] tx_wr_ptr,
  input  logic [PTR_W*CHANNELS-1:0] tx_rd_ptr,
  input  logic [CHANNELS-1:0]   intr_i,
  output logic                  sys_intr
);

  logic                acc, in_win, wr, rd, len_load;
  logic [5:0]          word;
  logic [47:0]         shadow;
  logic [15:0]         rd_word;
  logic [CHANNELS-1:0] status, intr_mask;

  assign acc      = slv_hit_i & slv_ce_i;
  assign in_win   = (slv_adr_i[11:7] == 5'd0);
  assign word     = slv_adr_i[6:1];
  assign wr       = acc & slv_we_i & in_win;
  assign rd       = acc & ~slv_we_i;
  assign len_load = wr & ((word == W_LEN_LO) | (word == W_LEN_HI));

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    localparam logic [5:0] CB = W_CH_BASE + 6'(W_CH_STRIDE * c);
    localparam logic [5:0] PB = W_PTR_BASE + 6'(W_PTR_STRIDE * c);
    ethpipe_csr_chan #(.CH_IDX(c), .PTR_W(PTR_W)) u_chan (
      .clk_125       (clk_125),
      .sys_rst       (sys_rst),
      .wr_start_lo   (wr && word == CB),
      .wr_start_hi   (wr && word == CB + 6'd1),
      .wr_ptr        (wr && word == PB),
      .wr_status     (wr && word == W_STATUS),
      .len_load      (len_load),
      .wdat          (slv_dat_i),
      .wsel          (slv_sel_i),
      .intr          (intr_i[c]),
      .dma_addr_start(dma_addr_start[30*c +: 30]),
      .tx_wr_ptr     (tx_wr_ptr[PTR_W*c +: PTR_W]),
      .status        (status[c]),
      .dma_load      (dma_load[c])
    );
  end

`ifdef ETHPIPE_CSR_INTR_MASK_EN
  always_ff @(posedge clk_125 or posedge sys_rst) begin
    if (sys_rst)
      intr_mask <= '1;
    else if (wr && word == W_MASK)
      intr_mask <= CHANNELS'(wr_merge(16'(intr_mask), slv_dat_i, slv_sel_i));
  end
`else
  assign intr_mask = '1;
`endif

  assign sys_intr = |(status & intr_mask);

  always_comb begin
    rd_word = '0;
    case (word)
      W_ID:          rd_word = {ID_BYTE, 8'(CHANNELS)};
      W_CNT0:        rd_word = global_counter[15:0];
      W_CNT0 + 6'd1: rd_word = shadow[15:0];
      W_CNT0 + 6'd2: rd_word = shadow[31:16];
      W_CNT0 + 6'd3: rd_word = shadow[47:32];
      W_STATUS:      rd_word = 16'(status);
`ifdef ETHPIPE_CSR_INTR_MASK_EN
      W_MASK:        rd_word = 16'(intr_mask);
`else
      W_MASK:        rd_word = '0;
`endif
      W_LEN_LO:      rd_word = {dma_length[13:0], 2'b00};
      W_LEN_HI:      rd_word = 16'(dma_length[19:14]);
      default:       ;
    endcase
    for (int c = 0; c < CHANNELS; c++) begin
      if (word == W_CH_BASE + 6'(W_CH_STRIDE * c))
        rd_word = {dma_addr_start[30*c +: 14], 2'b00};
      if (word == W_CH_BASE + 6'(W_CH_STRIDE * c + 1))
        rd_word = dma_addr_start[30*c+14 +: 16];
      if (word == W_CH_BASE + 6'(W_CH_STRIDE * c + 2))
        rd_word = {dma_addr_cur[30*c +: 14], 2'b00};
      if (word == W_CH_BASE + 6'(W_CH_STRIDE * c + 3))
        rd_word = dma_addr_cur[30*c+14 +: 16];
      if (word == W_PTR_BASE + 6'(W_PTR_STRIDE * c))
        rd_word = 16'(tx_wr_ptr[PTR_W*c +: PTR_W]);
      if (word == W_PTR_BASE + 6'(W_PTR_STRIDE * c + 1))
        rd_word = 16'(tx_rd_ptr[PTR_W*c +: PTR_W]);
    end
  end

  always_ff @(posedge clk_125 or posedge sys_rst) begin
    if (sys_rst) begin
      global_counter <= '0;
      shadow         <= '0;
      slv_dat_o      <= '0;
      dma_length     <= RST_DMA_LENGTH;
    end else begin
      global_counter <= global_counter + 64'd1;
      if (rd)
        slv_dat_o <= in_win ? lane_swap(rd_word) : '0;
      // upper words are frozen here so a multi-word read sees one counter value
      if (rd && in_win && word == W_CNT0)
        shadow <= global_counter[63:16];
      if (wr && word == W_LEN_LO)
        dma_length[13:0] <= 14'(wr_merge({dma_length[13:0], 2'b00}, slv_dat_i, slv_sel_i) >> 2);
      if (wr && word == W_LEN_HI)
        dma_length[19:14] <= 6'(wr_merge(16'(dma_length[19:14]), slv_dat_i, slv_sel_i));
    end
  end

endmodule

// File: tb/tb_ethpipe_csr.sv
// Randomized bench for ethpipe_csr against a register-map model kept in byte-address terms.
module tb_ethpipe_csr;

  localparam int NCH = 2;
  localparam int PW  = 14;

  logic                clk_125 = 1'b0;
  logic                sys_rst = 1'b0;
  logic                slv_hit_i = 1'b0, slv_ce_i = 1'b0, slv_we_i = 1'b0;
  logic [11:1]         slv_adr_i = '0;
  logic [15:0]         slv_dat_i = '0;
  logic [1:0]          slv_sel_i = '0;
  logic [15:0]         slv_dat_o;
  logic [63:0]         global_counter;
  logic [19:0]         dma_length;
  logic [30*NCH-1:0]   dma_addr_start, cur_bus;
  logic [NCH-1:0]      dma_load;
  logic [PW*NCH-1:0]   tx_wr_ptr, rdp_bus;
  logic [NCH-1:0]      intr_i = '0;
  logic                sys_intr;

  always #4 clk_125 = ~clk_125;

  ethpipe_csr #(.CHANNELS(NCH), .PTR_W(PW)) dut (
    .clk_125(clk_125), .sys_rst(sys_rst),
    .slv_hit_i(slv_hit_i), .slv_ce_i(slv_ce_i), .slv_we_i(slv_we_i),
    .slv_adr_i(slv_adr_i), .slv_dat_i(slv_dat_i), .slv_sel_i(slv_sel_i),
    .slv_dat_o(slv_dat_o), .global_counter(global_counter), .dma_length(dma_length),
    .dma_addr_start(dma_addr_start), .dma_addr_cur(cur_bus), .dma_load(dma_load),
    .tx_wr_ptr(tx_wr_ptr), .tx_rd_ptr(rdp_bus), .intr_i(intr_i), .sys_intr(sys_intr)
  );

  // model state: byte addresses / plain values
  logic [31:0]    m_start [NCH];
  logic [31:0]    m_cur   [NCH];
  logic [15:0]    m_ptr   [NCH];
  logic [15:0]    m_rdp   [NCH];
  logic [31:0]    m_len;
  logic [NCH-1:0] m_status, m_mask, exp_load;
  logic [63:0]    m_shadow;
  logic [15:0]    m_dat;
  logic [63:0]    cyc;
  int n_chk = 0, n_fail = 0;

  always @(posedge clk_125 or posedge sys_rst)
    if (sys_rst) cyc <= '0;
    else         cyc <= cyc + 64'd1;

  always_comb begin
    cur_bus = '0;
    rdp_bus = '0;
    for (int c = 0; c < NCH; c++) begin
      cur_bus[c*30 +: 30] = m_cur[c][31:2];
      rdp_bus[c*PW +: PW] = m_rdp[c][PW-1:0];
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] to_bus(input logic [15:0] r);
    return {r[7:0], r[15:8]};
  endfunction

  function automatic logic [15:0] lane_write(input logic [15:0] old, input logic [15:0] dat,
                                             input logic [1:0] sel);
    logic [15:0] r;
    r = old;
    if (sel[1]) r[7:0]  = dat[15:8];
    if (sel[0]) r[15:8] = dat[7:0];
    return r;
  endfunction

  // register-bit view of word w (word 2 handled by caller: live counter)
  function automatic logic [15:0] model_reg(input int w);
    logic [15:0] r;
    int c, k;
    r = '0;
    if (w == 0) r = {8'hE1, 8'(NCH)};
    else if (w >= 3 && w <= 5) r = m_shadow[(w-3)*16 +: 16];
    else if (w == 8) r = 16'(m_status);
`ifdef ETHPIPE_CSR_INTR_MASK_EN
    else if (w == 9) r = 16'(m_mask);
`endif
    else if (w == 10) r = m_len[15:0] & 16'hFFFC;
    else if (w == 11) r = 16'(m_len[21:16]);
    else if (w >= 16 && w < 48) begin
      c = (w - 16) / 4; k = (w - 16) % 4;
      if (c < NCH) begin
        if (k == 0) r = m_start[c][15:0] & 16'hFFFC;
        if (k == 1) r = m_start[c][31:16];
        if (k == 2) r = m_cur[c][15:0] & 16'hFFFC;
        if (k == 3) r = m_cur[c][31:16];
      end
    end else if (w >= 48) begin
      c = (w - 48) / 2; k = (w - 48) % 2;
      if (c < NCH) r = (k == 0) ? m_ptr[c] : m_rdp[c];
    end
    return r;
  endfunction

  task automatic model_write(input int w, input logic [15:0] dat, input logic [1:0] sel);
    logic [15:0] m, clr;
    int c, k;
    m = lane_write(model_reg(w), dat, sel);
    if (w == 8) begin
      clr = sel[1] ? 16'(dat[15:8]) : 16'h0;
      m_status = m_status & ~clr[NCH-1:0];
    end
`ifdef ETHPIPE_CSR_INTR_MASK_EN
    if (w == 9) m_mask = m[NCH-1:0];
`endif
    if (w == 10) begin m_len[15:2] = m[15:2]; exp_load = '1; end
    if (w == 11) begin m_len[21:16] = m[5:0]; exp_load = '1; end
    if (w >= 16 && w < 48) begin
      c = (w - 16) / 4; k = (w - 16) % 4;
      if (c < NCH && k == 0) begin m_start[c][15:2] = m[15:2]; exp_load[c] = 1'b1; end
      if (c < NCH && k == 1) begin m_start[c][31:16] = m; exp_load[c] = 1'b1; end
    end
    if (w >= 48) begin
      c = (w - 48) / 2; k = (w - 48) % 2;
      if (c < NCH && k == 0) m_ptr[c] = m & 16'((1 << PW) - 1);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_start[c] = 32'h1000_0000 + 32'(c) * 32'h0010_0000;
      m_ptr[c]   = '0;
    end
    m_len = 32'h0001_0000; m_status = '0; m_mask = '1; m_shadow = '0;
    m_dat = '0; exp_load = '0;
  endtask

  task automatic check_outputs();
    chk("dma_load", dma_load, exp_load);
    chk("dma_length", dma_length, m_len[21:2]);
    for (int c = 0; c < NCH; c++) begin
      chk($sformatf("dma_addr_start%0d", c), dma_addr_start[c*30 +: 30], m_start[c][31:2]);
      chk($sformatf("tx_wr_ptr%0d", c), tx_wr_ptr[c*PW +: PW], m_ptr[c][PW-1:0]);
    end
    chk("sys_intr", sys_intr, |(m_status & m_mask));
    chk("global_counter", global_counter, cyc);
    chk("slv_dat_o", slv_dat_o, m_dat);
  endtask

  // called at a negedge; drives one cycle, returns at the following negedge
  task automatic do_access(input bit hit, input bit ce, input bit we, input logic [4:0] hi,
                           input int w, input logic [15:0] dat, input logic [1:0] sel,
                           input logic [NCH-1:0] intr);
    logic [63:0] c0;
    logic [15:0] rexp;
    bit acc, inw;
    acc = hit & ce; inw = (hi == 5'd0); c0 = cyc;
    rexp = (w == 2) ? c0[15:0] : model_reg(w);
    slv_hit_i = hit; slv_ce_i = ce; slv_we_i = we; slv_adr_i = {hi, 6'(w)};
    slv_dat_i = dat; slv_sel_i = sel; intr_i = intr;
    @(negedge clk_125);
    slv_hit_i = 1'b0; slv_ce_i = 1'b0; slv_we_i = 1'b0; intr_i = '0;
    exp_load = '0;
    if (acc && !we) begin
      m_dat = inw ? to_bus(rexp) : 16'h0;
      if (inw && w == 2) m_shadow = c0 >> 16;
    end
    if (acc && we && inw) model_write(w, dat, sel);
    m_status = m_status | intr;
    check_outputs();
  endtask

  task automatic idle(input logic [NCH-1:0] intr);
    do_access(1'b0, 1'b0, 1'b0, 5'd0, 0, 16'h0, 2'b00, intr);
  endtask

  task automatic abort_write(input int w, input logic [15:0] dat);
    slv_hit_i = 1'b1; slv_ce_i = 1'b1; slv_we_i = 1'b1; slv_adr_i = {5'd0, 6'(w)};
    slv_dat_i = dat; slv_sel_i = 2'b11;
    #1 sys_rst = 1'b1;
    #1;
    chk("abort_ptr0", tx_wr_ptr[PW-1:0], 0);
    chk("abort_load", dma_load, 0);
    chk("abort_counter", global_counter, 0);
    chk("abort_length", dma_length, 20'h04000);
    @(negedge clk_125);
    slv_hit_i = 1'b0; slv_ce_i = 1'b0; slv_we_i = 1'b0;
    @(negedge clk_125);
    sys_rst = 1'b0;
    model_reset();
    idle('0);
    idle('0);
  endtask

  int sel_words [9] = '{0, 2, 3, 4, 5, 8, 9, 10, 11};

  initial begin
    #50_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [63:0] snap;
    int w;
    for (int c = 0; c < NCH; c++) begin
      m_cur[c] = {$urandom, 2'b00} & 32'hFFFF_FFFC;
      m_rdp[c] = 16'($urandom) & 16'((1 << PW) - 1);
    end
    model_reset();
    #1 sys_rst = 1'b1;
    repeat (3) @(negedge clk_125);
    check_outputs();
    sys_rst = 1'b0;

    do_access(1, 1, 0, 0, 'h00, 0, 0, 0);
    chk("id_read", slv_dat_o, 16'h02E1);
    do_access(1, 1, 0, 0, 'h14, 0, 0, 0);
    chk("ch1_start_lo", slv_dat_o, 16'h0000);
    do_access(1, 1, 0, 0, 'h15, 0, 0, 0);
    chk("ch1_start_hi", slv_dat_o, 16'h1010);
    chk("sys_intr_reset", sys_intr, 0);

    do_access(1, 1, 1, 0, 'h10, 16'hFC00, 2'b10, 0);
    chk("start0_bits7_2", dma_addr_start[5:0], 6'h3F);
    chk("start0_other_lane", dma_addr_start[13:6], 8'h00);
    chk("load_pulse", dma_load, 2'b01);
    idle('0);
    chk("load_one_cycle", dma_load, 2'b00);
    do_access(1, 1, 1, 0, 'h0A, 16'h0400, 2'b11, 0);
    do_access(1, 1, 1, 0, 'h11, 16'h2233, 2'b01, 0);
    chk("load_back_to_back", dma_load, 2'b01);

    snap = cyc;
    do_access(1, 1, 0, 0, 'h02, 0, 0, 0);
    chk("snap_live_lo", slv_dat_o, to_bus(snap[15:0]));
    repeat (1000) @(negedge clk_125);
    do_access(1, 1, 0, 0, 'h03, 0, 0, 0);
    chk("snap_word1", slv_dat_o, to_bus(snap[31:16]));

    idle(2'b10);
    do_access(1, 1, 1, 0, 'h08, 16'h0200, 2'b10, 2'b10);
    chk("set_wins_intr", sys_intr, 1);
    do_access(1, 1, 1, 0, 'h08, 16'h0200, 2'b10, 0);
    chk("w1c_clears", sys_intr, 0);

`ifdef ETHPIPE_CSR_INTR_MASK_EN
    do_access(1, 1, 1, 0, 'h09, 16'h0000, 2'b10, 0);
    idle(2'b01);
    chk("masked_sys_intr", sys_intr, 0);
    do_access(1, 1, 0, 0, 'h08, 0, 0, 0);
    chk("masked_status", slv_dat_o, 16'h0100);
    do_access(1, 1, 1, 0, 'h09, 16'hFF00, 2'b10, 0);
    chk("unmasked_sys_intr", sys_intr, 1);
`else
    do_access(1, 1, 1, 0, 'h09, 16'h0000, 2'b10, 0);
    do_access(1, 1, 0, 0, 'h09, 0, 0, 0);
    chk("mask_word_zero", slv_dat_o, 16'h0000);
    idle(2'b01);
    chk("unmasked_sys_intr", sys_intr, 1);
`endif
    do_access(1, 1, 1, 0, 'h08, 16'h0300, 2'b10, 0);

    do_access(1, 1, 1, 0, 'h30, 16'h3412, 2'b11, 0);
    chk("ptr0_written", tx_wr_ptr[PW-1:0], 14'h1234);
    abort_write('h30, 16'h5566);
    abort_write('h0A, 16'h1111);

    for (int i = 0; i < 700; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        for (int c = 0; c < NCH; c++) begin
          m_cur[c] = $urandom & 32'hFFFF_FFFC;
          m_rdp[c] = 16'($urandom) & 16'((1 << PW) - 1);
        end
      end
      case ($urandom_range(0, 3))
        0: w = $urandom_range(0, 63);
        1: w = 16 + $urandom_range(0, 7);
        2: w = 48 + $urandom_range(0, 3);
        default: w = sel_words[$urandom_range(0, 8)];
      endcase
      do_access($urandom_range(0, 19) != 0, $urandom_range(0, 4) != 0, $urandom_range(0, 1) == 1,
                ($urandom_range(0, 9) == 0) ? 5'($urandom_range(1, 31)) : 5'd0,
                w, 16'($urandom), 2'($urandom),
                ($urandom_range(0, 4) == 0) ? NCH'($urandom) : '0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
